// File: rtl/gpu_prefetch.sv
// gpu_prefetch -- instruction prefetch queue for a 16-bit instruction stream
// fetched from 32-bit program memory.
//
// A three-state request FSM keeps a QDEPTH-longword queue topped up. At most
// one fetch is in flight at any time, so back-to-back fetches deliver one
// longword every two cycles. The consumer pops 16-bit instructions from the
// head of the queue. Its byte PC selects which halfword of the head longword
// is presented.
//
// Parameter:
//   QDEPTH      queue depth in longwords (power of two, 2..8)
//
// Ports:
//   sys_clk     clock; all state changes on its rising edge
//   reset       synchronous active-high reset
//   jump        one-cycle strobe: flush the queue and restart fetch at jump_addr
//   jump_addr   byte address of the jump target (bit 0 ignored)
//   big_instr   halfword order within a longword (1: upper halfword first)
//   progreq     program-fetch request
//   progaddr    longword fetch address (byte address bits 23:2)
//   progack     request-accepted strobe; data follows on the next cycle
//   mem_data    fetch data
//   pabort      aborts the fetch whose data arrives this cycle
//   instr       head instruction (0 when not valid)
//   instr_pc    byte address of instr
//   instr_valid instr is valid
//   instr_take  consumer pop; ignored when instr_valid is low
//
// Build option:
//   GPU_PREFETCH_BYPASS_EN  when defined, data arriving while the queue is
//                           empty is presented on instr in the same cycle.
//
// State table:
//   state  | meaning
//   IDLE   | no request; queue full, or waiting for the first jump
//   REQ    | progreq high, progaddr held until progack
//   DATA   | accepted fetch data is on mem_data this cycle
module gpu_prefetch #(
  parameter int QDEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        jump,
  input  logic [23:0] jump_addr,
  input  logic        big_instr,
  output logic        progreq,
  output logic [21:0] progaddr,
  input  logic        progack,
  input  logic [31:0] mem_data,
  output logic        pabort,
  output logic [15:0] instr,
  output logic [23:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_take
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [31:0]   q_mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          started;
  logic [21:0]   addr_q;
  logic [23:0]   pc_q;

  logic          in_data, q_empty, byp, take, pop, byp_consumed, wr, space, sel_hi;
  logic [31:0]   head_word;

  assign in_data = (state == S_DATA);
  assign q_empty = (count == '0);

`ifdef GPU_PREFETCH_BYPASS_EN
  assign byp = in_data && q_empty && !jump && !reset;
`else
  assign byp = 1'b0;
`endif

  assign head_word   = byp ? mem_data : q_mem[rd_ptr];
  assign instr_valid = !q_empty || byp;

  // A jump wins over a take, and it also wins over the write of any data that arrives in the same cycle.
  assign take         = instr_take && instr_valid && !jump;
  assign pop          = take && pc_q[1] && !q_empty;
  // When a bypassed longword is fully consumed in its arrival cycle, it never needs a queue slot.
  assign byp_consumed = take && pc_q[1] && byp;
  assign wr           = in_data && !jump && !byp_consumed;

  assign count_nxt = count + (wr ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
  assign space     = (count_nxt < CW'(QDEPTH));

  // Dropping the request combinationally on a jump makes sure a jump in REQ can never be accepted.
  assign progreq  = (state == S_REQ) && !jump && !reset;
  assign pabort   = in_data && jump && !reset;
  assign progaddr = addr_q;
  assign instr_pc = pc_q;

  assign sel_hi = big_instr ? !pc_q[1] : pc_q[1];
  assign instr  = !instr_valid ? 16'h0000 :
                  (sel_hi ? head_word[31:16] : head_word[15:0]);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (started && space) state_nxt = S_REQ;
      S_REQ:   if (progack) state_nxt = S_DATA;
      S_DATA:  state_nxt = space ? S_REQ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      started <= 1'b0;
      addr_q  <= '0;
      pc_q    <= '0;
    end else if (jump) begin
      state   <= S_REQ;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      started <= 1'b1;
      addr_q  <= jump_addr[23:2];
      pc_q    <= jump_addr & 24'hFFFFFE;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
        addr_q <= addr_q + 22'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (take) pc_q <= pc_q + 24'd2;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset && wr) q_mem[wr_ptr] <= mem_data;
  end

endmodule

// File: tb/tb_gpu_prefetch.sv
module tb_gpu_prefetch;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        jump;
  logic [23:0] jump_addr;
  logic        big_instr;
  logic        progreq;
  logic [21:0] progaddr;
  logic        progack;
  logic [31:0] mem_data;
  logic        pabort;
  logic [15:0] instr;
  logic [23:0] instr_pc;
  logic        instr_valid;
  logic        instr_take;

  logic        ack_en;
  logic        use_fixed;
  logic [31:0] mem_word = 32'hDEADBEEF;
  int          n_ack = 0;
  int          base;
  int          total = 0;
  int          bad = 0;

`ifdef GPU_PREFETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  gpu_prefetch #(.QDEPTH(4)) dut (
    .sys_clk(sys_clk), .reset(reset), .jump(jump), .jump_addr(jump_addr),
    .big_instr(big_instr), .progreq(progreq), .progaddr(progaddr),
    .progack(progack), .mem_data(mem_data), .pabort(pabort), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_take(instr_take)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] pat(input logic [21:0] a);
    return {4'h1, a[11:0], 4'h2, a[11:0]};
  endfunction

  // Memory responder: it acks immediately and returns data on the cycle after the ack.
  assign progack  = ack_en && progreq;
  assign mem_data = mem_word;
  always @(posedge sys_clk) begin
    if (progack) begin
      n_ack    <= n_ack + 1;
      mem_word <= use_fixed ? 32'h12345678 : pat(progaddr);
    end else begin
      mem_word <= 32'hDEADBEEF;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; jump = 0; jump_addr = '0; big_instr = 1; instr_take = 0;
    ack_en = 0; use_fixed = 0;
    tick(); tick(); tick();
    chk("rst_progreq", progreq, 0);
    chk("rst_pabort", pabort, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_addr", progaddr, 0);
    reset = 0;
    tick(); tick();
    chk("no_req_before_jump", progreq, 0);

    // Jump to 0xF03000 and fill the queue without any takes.
    ack_en = 1; jump = 1; jump_addr = 24'hF03000; base = n_ack;
    tick();
    jump = 0; #1;
    chk("j1_req", progreq, 1);
    chk("j1_addr", progaddr, 22'h3C0C00);
    chk("j1_valid_req", instr_valid, 0);
    tick();
    chk("j1_data_noreq", progreq, 0);
    chk("j1_valid_data", instr_valid, BYP);
    if (BYP) chk("j1_byp_instr", instr, 16'h1C00);
    tick();
    chk("j1_valid", instr_valid, 1);
    chk("j1_instr", instr, 16'h1C00);
    chk("j1_pc", instr_pc, 24'hF03000);
    chk("j1_addr2", progaddr, 22'h3C0C01);
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("full_idle", progreq, 0);
    chk("full_addr", progaddr, 22'h3C0C04);
    tick(); tick();
    chk("full_hold", progreq, 0);
    chk("ack_count", n_ack - base, 4);

    // Consume the head longword; refetch starts the cycle after the pop.
    instr_take = 1; #1;
    chk("take_hi", instr, 16'h1C00);
    tick();
    chk("take_lo", instr, 16'h2C00);
    chk("take_pc", instr_pc, 24'hF03002);
    chk("take_noreq", progreq, 0);
    tick();
    instr_take = 0; #1;
    chk("pop_req", progreq, 1);
    chk("pop_addr", progaddr, 22'h3C0C04);
    chk("pop_instr", instr, 16'h1C01);
    chk("pop_pc", instr_pc, 24'hF03004);
    big_instr = 0; #1;
    chk("little_order", instr, 16'h2C01);
    big_instr = 1;

    // Jump while in DATA: abort and discard the data that is in flight.
    tick();
    jump = 1; jump_addr = 24'hF04000; #1;
    chk("abort_pabort", pabort, 1);
    chk("abort_noreq", progreq, 0);
    tick();
    jump = 0; #1;
    chk("abort_once", pabort, 0);
    chk("abort_flush", instr_valid, 0);
    chk("abort_addr", progaddr, 22'h3C1000);
    chk("abort_req", progreq, 1);
    chk("abort_pc", instr_pc, 24'hF04000);
    tick();
    chk("abort_data_valid", instr_valid, BYP);
    tick();
    chk("abort_new_instr", instr, 16'h1000);
    chk("abort_new_valid", instr_valid, 1);

    // Jump to an odd halfword: the first-ordered halfword is skipped.
    use_fixed = 1; jump = 1; jump_addr = 24'hF03002;
    tick();
    jump = 0;
    tick(); tick();
    chk("odd_instr", instr, 16'h5678);
    chk("odd_pc", instr_pc, 24'hF03002);
    chk("odd_valid", instr_valid, 1);
    ack_en = 0; use_fixed = 0; #1;
    chk("odd_next_addr", progaddr, 22'h3C0C01);
    chk("odd_req", progreq, 1);

    // Jump while in REQ: the request is dropped and no abort is issued.
    jump = 1; jump_addr = 24'hF05006; #1;
    chk("jreq_noreq", progreq, 0);
    chk("jreq_nopabort", pabort, 0);
    tick();
    jump = 0; #1;
    chk("jreq_addr", progaddr, 22'h3C1401);
    chk("jreq_req", progreq, 1);
    chk("jreq_valid", instr_valid, 0);
    chk("jreq_pc", instr_pc, 24'hF05006);

    // Reset in REQ, together with a jump and a take.
    reset = 1; jump = 1; jump_addr = 24'h123456; instr_take = 1; ack_en = 1;
    tick();
    reset = 0; jump = 0; instr_take = 0; #1;
    chk("rst2_progreq", progreq, 0);
    chk("rst2_pabort", pabort, 0);
    chk("rst2_valid", instr_valid, 0);
    chk("rst2_instr", instr, 0);
    chk("rst2_pc", instr_pc, 0);
    chk("rst2_addr", progaddr, 0);
    tick(); tick();
    chk("rst2_hold", progreq, 0);

    // Write and pop in the same cycle leave the occupancy unchanged.
    jump = 1; jump_addr = 24'h000000;
    tick();
    jump = 0;
    tick(); tick();
    instr_take = 1;
    tick(); tick();
    instr_take = 0; #1;
    chk("wp_valid", instr_valid, 1);
    chk("wp_instr", instr, 16'h1001);
    chk("wp_pc", instr_pc, 24'h000004);
    chk("wp_addr", progaddr, 22'h000002);
    chk("wp_req", progreq, 1);

    // progaddr wraps modulo 2^22.
    jump = 1; jump_addr = 24'hFFFFFC;
    tick();
    jump = 0; #1;
    chk("wrap_addr0", progaddr, 22'h3FFFFF);
    tick(); tick();
    chk("wrap_addr1", progaddr, 22'h000000);
    chk("wrap_instr", instr, 16'h1FFF);
    chk("wrap_pc", instr_pc, 24'hFFFFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpu_prefetch.md
GPU_PREFETCH -- requirements
Module: gpu_prefetch

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, sets the instruction queue depth in longwords (power of two, 2..8).
REQ-002 SHALL have port sys_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port jump, input, 1 bit, a one-cycle strobe that loads a new fetch PC and flushes.
REQ-005 SHALL have port jump_addr, input, 24 bits, the byte address of the jump target (bit 0 ignored).
REQ-006 SHALL have port big_instr, input, 1 bit, the halfword order within a longword.
REQ-007 SHALL have port progreq, output, 1 bit, the program-fetch request.
REQ-008 SHALL have port progaddr, output, 22 bits, the longword fetch address (byte address bits 23:2).
REQ-009 SHALL have port progack, input, 1 bit, the request-accepted strobe.
REQ-010 SHALL have port mem_data, input, 32 bits, fetch data, valid on the cycle after progack.
REQ-011 SHALL have port pabort, output, 1 bit, aborts an accepted fetch whose data is still in flight.
REQ-012 SHALL have port instr, output, 16 bits, the head instruction.
REQ-013 SHALL have port instr_pc, output, 24 bits, the byte address of instr.
REQ-014 SHALL have port instr_valid, output, 1 bit, indicating instr is valid.
REQ-015 SHALL have port instr_take, input, 1 bit, the consumer pop; ignored when instr_valid=0.

Function
REQ-016 SHALL implement a request FSM with three states:
- IDLE: progreq=0.
- REQ: progreq=1 and progaddr stable until progack.
- DATA: data is due this cycle.
REQ-017 SHALL transition IDLE->REQ when occupancy plus outstanding is less than QDEPTH, and REQ->DATA on progack.
REQ-018 SHALL leave DATA for REQ if space remains after the write, else for IDLE; back-to-back requests yield one longword every 2 cycles.
REQ-019 SHALL write mem_data to the queue tail and advance progaddr by 1 in DATA; progaddr wraps modulo 2^22.
REQ-020 SHALL allow at most one outstanding fetch.
REQ-021 SHALL select the halfword by instr_pc[1]:
- big_instr=1: pc[1]=0 selects mem_data[31:16], pc[1]=1 selects [15:0].
- big_instr=0: the order is reversed.
REQ-022 SHALL advance instr_pc by 2 on a take; the queue head pops when a take consumes the second halfword of a longword.
REQ-023 SHALL, on a jump:
- Empty the queue.
- Set instr_pc to jump_addr with bit 0 cleared.
- Set progaddr to jump_addr[23:2].
- Enter REQ on the next cycle.
REQ-024 SHALL, on a jump targeting pc[1]=1, mark the first longword so its first-ordered halfword is skipped.
REQ-025 SHALL assert pabort for exactly one cycle when a jump coincides with DATA; that cycle's data SHALL be discarded and not written.
REQ-026 SHALL handle a jump in REQ as follows: drop the pending request, take no pabort, and present the new progaddr on the next cycle.
REQ-027 SHALL give jump priority over a simultaneous instr_take and data write.
REQ-028 SHALL honour a simultaneous queue write and pop in the same cycle; occupancy is unchanged.
REQ-029 SHALL, when the queue is full, hold IDLE; the fetch resumes the cycle after a pop frees a slot.
REQ-030 SHALL assert instr_valid only while the queue is non-empty.

Reset
REQ-031 SHALL, on reset, clear the queue and set progreq=0, pabort=0, instr_valid=0, instr=0, instr_pc=0, progaddr=0, FSM=IDLE.
REQ-032 SHALL make reset override jump, progack and instr_take in the same cycle; data in flight during reset SHALL be discarded.
REQ-033 SHALL keep progreq low after reset until the first jump.

Configuration
REQ-034 SHALL support macro GPU_PREFETCH_BYPASS_EN:
- Defined: in DATA with an empty queue, mem_data is presented on instr and instr_valid=1 in the same cycle, and the longword is still written unless fully consumed.
- Undefined: instr_valid rises no earlier than the cycle after DATA.

Verification
REQ-035 SHALL cover reset, then jump to 0xF03000 with progack on the first cycle of every REQ -> progaddr=0x3C0C00, then 0x3C0C01, and so on; the first instr_valid occurs per REQ-034.
REQ-036 SHALL cover a jump to 0xF03002 with big_instr=1 and mem_data=0x12345678 -> first instr=0x5678, instr_pc=0xF03002.
REQ-037 SHALL cover instr_take held low with QDEPTH=4 -> exactly 4 progacks, then progreq=0; one longword popped -> progreq=1 on the next cycle.
REQ-038 SHALL cover a jump in DATA to 0xF04000 -> pabort=1 for one cycle, stale data not presented, next progaddr=0x3C1000.
REQ-039 SHALL cover reset asserted mid-REQ with jump=1 and instr_take=1 in that cycle -> all outputs at their REQ-031 values on the next cycle.
